// File: rtl/dac_config_loader.sv
// Command-driven loader for the two 128-unit DAC arrays: assembles a word in a
// serial chain, transfers it to the low/high unit registers and drives enables.
module dac_config_loader (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   input  logic [2:0]   cmd,
   input  logic [7:0]   din,
   output logic         cmd_ready,
   output logic [127:0] state_l,
   output logic [127:0] state_h,
   output logic [3:0]   en_l,
   output logic [3:0]   en_h,
   output logic         sdo,
   output logic [1:0]   therm_err
);

   localparam logic [2:0] OP_NOP      = 3'd0;
   localparam logic [2:0] OP_SHIFT1   = 3'd1;
   localparam logic [2:0] OP_SHIFT8   = 3'd2;
   localparam logic [2:0] OP_LOAD_L   = 3'd3;
   localparam logic [2:0] OP_LOAD_H   = 3'd4;
   localparam logic [2:0] OP_READBACK = 3'd5;
   localparam logic [2:0] OP_SET_EN   = 3'd6;
   localparam logic [2:0] OP_CLEAR    = 3'd7;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } fsm_t;

   fsm_t           fsm_r;
   fsm_t           fsm_nxt_s;
   logic           cmd_ready_r;
   logic           cmd_ready_nxt_s;
   logic           accept_s;

   logic [127:0]   chain_r;
   logic [127:0]   chain_nxt_s;
   logic [6:0]     byte_sr_r;
   logic [6:0]     byte_sr_nxt_s;
   logic [2:0]     cnt_r;
   logic [2:0]     cnt_nxt_s;
   logic [127:0]   state_l_r;
   logic [127:0]   state_l_nxt_s;
   logic [127:0]   state_h_r;
   logic [127:0]   state_h_nxt_s;
   logic [3:0]     en_l_r;
   logic [3:0]     en_l_nxt_s;
   logic [3:0]     en_h_r;
   logic [3:0]     en_h_nxt_s;
   logic [1:0]     therm_err_r;
   logic [1:0]     therm_err_nxt_s;

   // A run of ones anchored at bit 0 turns into a single carry out when
   // incremented, so it shares no set bit with its successor.
   function automatic logic is_therm(input logic [127:0] w);
      return ((w & (w + 128'd1)) == 128'd0);
   endfunction

   assign accept_s = cmd_valid && (fsm_r == ST_IDLE);

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_r <= ST_IDLE;
      end else begin
         fsm_r <= fsm_nxt_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      fsm_nxt_s = fsm_r;
      case (fsm_r)
         ST_IDLE: begin
            if (accept_s && (cmd == OP_SHIFT8)) begin
               fsm_nxt_s = ST_BURST;
            end else begin
               fsm_nxt_s = ST_IDLE;
            end
         end
         ST_BURST: begin
            if (cnt_r == 3'd0) begin
               fsm_nxt_s = ST_IDLE;
            end else begin
               fsm_nxt_s = ST_BURST;
            end
         end
         default: fsm_nxt_s = ST_IDLE;
      endcase
   end

   // FSM output decode, registered one edge ahead so cmd_ready tracks IDLE exactly
   always_comb begin
      cmd_ready_nxt_s = 1'b0;
      case (fsm_nxt_s)
         ST_IDLE:  cmd_ready_nxt_s = 1'b1;
         ST_BURST: cmd_ready_nxt_s = 1'b0;
         default:  cmd_ready_nxt_s = 1'b1;
      endcase
   end

   // Datapath next-value logic for chain, burst shifter and output registers
   always_comb begin
      chain_nxt_s     = chain_r;
      byte_sr_nxt_s   = byte_sr_r;
      cnt_nxt_s       = cnt_r;
      state_l_nxt_s   = state_l_r;
      state_h_nxt_s   = state_h_r;
      en_l_nxt_s      = en_l_r;
      en_h_nxt_s      = en_h_r;
      therm_err_nxt_s = therm_err_r;
      if (fsm_r == ST_BURST) begin
         chain_nxt_s   = {chain_r[126:0], byte_sr_r[6]};
         byte_sr_nxt_s = {byte_sr_r[5:0], 1'b0};
         if (cnt_r == 3'd0) begin
            cnt_nxt_s = cnt_r;
         end else begin
            cnt_nxt_s = cnt_r - 3'd1;
         end
      end else if (accept_s) begin
         case (cmd)
            OP_NOP: begin
               chain_nxt_s = chain_r;
            end
            OP_SHIFT1: begin
               chain_nxt_s = {chain_r[126:0], din[0]};
            end
            OP_SHIFT8: begin
               // MSB goes in now; the remaining seven follow from byte_sr
               chain_nxt_s   = {chain_r[126:0], din[7]};
               byte_sr_nxt_s = din[6:0];
               cnt_nxt_s     = 3'd6;
            end
            OP_LOAD_L: begin
               state_l_nxt_s = chain_r;
               if (!is_therm(chain_r)) begin
                  therm_err_nxt_s[0] = 1'b1;
               end else begin
                  therm_err_nxt_s[0] = therm_err_r[0];
               end
            end
            OP_LOAD_H: begin
               state_h_nxt_s = chain_r;
               if (!is_therm(chain_r)) begin
                  therm_err_nxt_s[1] = 1'b1;
               end else begin
                  therm_err_nxt_s[1] = therm_err_r[1];
               end
            end
            OP_READBACK: begin
               if (din[0]) begin
                  chain_nxt_s = state_h_r;
               end else begin
                  chain_nxt_s = state_l_r;
               end
            end
            OP_SET_EN: begin
               en_l_nxt_s = din[3:0];
               en_h_nxt_s = din[7:4];
            end
            OP_CLEAR: begin
               chain_nxt_s     = 128'd0;
               state_l_nxt_s   = 128'd0;
               state_h_nxt_s   = 128'd0;
               en_l_nxt_s      = 4'd0;
               en_h_nxt_s      = 4'd0;
               therm_err_nxt_s = 2'd0;
            end
            default: begin
               chain_nxt_s = chain_r;
            end
         endcase
      end else begin
         chain_nxt_s = chain_r;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_r     <= 128'd0;
         byte_sr_r   <= 7'd0;
         cnt_r       <= 3'd0;
         state_l_r   <= 128'd0;
         state_h_r   <= 128'd0;
         en_l_r      <= 4'd0;
         en_h_r      <= 4'd0;
         therm_err_r <= 2'd0;
         cmd_ready_r <= 1'b1;
      end else begin
         chain_r     <= chain_nxt_s;
         byte_sr_r   <= byte_sr_nxt_s;
         cnt_r       <= cnt_nxt_s;
         state_l_r   <= state_l_nxt_s;
         state_h_r   <= state_h_nxt_s;
         en_l_r      <= en_l_nxt_s;
         en_h_r      <= en_h_nxt_s;
         therm_err_r <= therm_err_nxt_s;
         cmd_ready_r <= cmd_ready_nxt_s;
      end
   end

   assign cmd_ready = cmd_ready_r;
   assign state_l   = state_l_r;
   assign state_h   = state_h_r;
   assign en_l      = en_l_r;
   assign en_h      = en_h_r;
   assign sdo       = chain_r[127];
   assign therm_err = therm_err_r;

endmodule
